// File: rtl/ysyx_22051013_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU single-port memory arbiter.
// Holds the bus widths, the starvation bound and the FSM state encoding.
package ysyx_22051013_mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W     = 64;
    localparam int unsigned ARB_DATA_W     = 64;
    localparam int unsigned ARB_STARVE_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IF_REQ  = 3'd1,
        ST_IF_WAIT = 3'd2,
        ST_LS_REQ  = 3'd3,
        ST_LS_WAIT = 3'd4
    } arb_state_t;

endpackage

// File: rtl/ysyx_22051013_mem_arb_req_reg.sv
// Memory request field register: selects IFU or LSU fields and loads them on the grant edge.
// Fields are held unchanged for the whole transaction since only a grant reloads them.
module ysyx_22051013_mem_arb_req_reg
    import ysyx_22051013_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_sel_ls,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_ls_wen,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_wmask,
    output logic                o_wen,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wmask
);

    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (i_load) begin
            if (i_sel_ls) begin
                r_wen   <= i_ls_wen;
                r_addr  <= i_ls_addr;
                r_wdata <= i_ls_wdata;
                r_wmask <= i_ls_wmask;
            end else begin
                // Fetches are plain doubleword reads.
                r_wen   <= 1'b0;
                r_addr  <= i_if_addr;
                r_wdata <= '0;
                r_wmask <= '0;
            end
        end
    end

    assign o_wen   = r_wen;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_wmask = r_wmask;

endmodule

// File: rtl/ysyx_22051013_mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// LSU has priority; a pending fetch wins after STARVE_MAX consecutive LSU grants.
module ysyx_22051013_mem_arb
    import ysyx_22051013_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned DATA_W     = ARB_DATA_W,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_busy,
    input  logic                ls_req,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_done,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [CNT_W-1:0]   r_starve;
    logic               r_drop;
    logic               r_if_rvalid;
    logic [DATA_W-1:0]  r_if_rdata;
    logic               r_ls_done;
    logic [DATA_W-1:0]  r_ls_rdata;
    logic               w_grant_if;
    logic               w_grant_ls;
    logic               w_if_ok;
    logic               w_starved;
    logic               w_if_phase;

    assign w_if_ok    = if_req & ~if_flush;
    assign w_starved  = (r_starve == CNT_W'(STARVE_MAX));
    assign w_if_phase = (r_state == ST_IF_REQ) || (r_state == ST_IF_WAIT);

    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_ls = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ls_req && !(w_if_ok && w_starved)) begin
                    w_next     = ST_LS_REQ;
                    w_grant_ls = 1'b1;
                end else if (w_if_ok) begin
                    w_next     = ST_IF_REQ;
                    w_grant_if = 1'b1;
                end
            end
            ST_IF_REQ:  if (mem_ready)  w_next = ST_IF_WAIT;
            ST_IF_WAIT: if (mem_rvalid) w_next = ST_IDLE;
            ST_LS_REQ:  if (mem_ready)  w_next = ST_LS_WAIT;
            ST_LS_WAIT: if (mem_rvalid) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_starve    <= '0;
            r_drop      <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_done   <= 1'b0;
            r_ls_rdata  <= '0;
        end else begin
            r_state <= w_next;

            if (w_grant_if || (r_state == ST_IDLE && !if_req))
                r_starve <= '0;
            else if (w_grant_ls && if_req && !w_starved)
                r_starve <= r_starve + CNT_W'(1);

            if (w_next == ST_IDLE)
                r_drop <= 1'b0;
            else if (w_if_phase && if_flush)
                r_drop <= 1'b1;

            // A flush arriving with the response itself also discards it.
            r_if_rvalid <= (r_state == ST_IF_WAIT) && mem_rvalid && !r_drop && !if_flush;
            if ((r_state == ST_IF_WAIT) && mem_rvalid && !r_drop && !if_flush)
                r_if_rdata <= mem_rdata;

            r_ls_done <= (r_state == ST_LS_WAIT) && mem_rvalid;
            if ((r_state == ST_LS_WAIT) && mem_rvalid)
                r_ls_rdata <= mem_rdata;
        end
    end

    ysyx_22051013_mem_arb_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grant_if | w_grant_ls),
        .i_sel_ls   (w_grant_ls),
        .i_if_addr  (if_addr),
        .i_ls_wen   (ls_wen),
        .i_ls_addr  (ls_addr),
        .i_ls_wdata (ls_wdata),
        .i_ls_wmask (ls_wmask),
        .o_wen      (mem_wen),
        .o_addr     (mem_addr),
        .o_wdata    (mem_wdata),
        .o_wmask    (mem_wmask)
    );

    assign mem_valid = (r_state == ST_IF_REQ) || (r_state == ST_LS_REQ);
    assign if_busy   = (if_req & ~r_if_rvalid) | w_if_phase;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_done   = r_ls_done;
    assign ls_rdata  = r_ls_rdata;

endmodule
